// File: rtl/mem_hex_dump_pkg.sv
// Shared constants and state encoding for the memory hex dumper.
package mem_hex_dump_pkg;
  localparam logic [7:0] chr_lf  = 8'h0a;
  localparam logic [7:0] chr_spc = 8'h20;
  localparam logic [7:0] chr_atm = 8'h40;

  typedef enum logic [2:0] {IDLE, ADR, FETCH, WAIT, HEX, SEP, FIN} state_t;
endpackage

// File: rtl/mem_hex_dump_nib.sv
// Nibble to lowercase ASCII hex digit.
module mem_hex_dump_nib (
  input  logic [3:0] i_nib,
  output logic [7:0] o_chr
);
  always_comb o_chr = (i_nib < 4'd10) ? (8'h30 + {4'h0, i_nib}) : (8'h57 + {4'h0, i_nib});
endmodule

// File: rtl/mem_hex_dump.sv
// Streams a memory region as "@addr" header plus space/LF separated hex words
// over a valid/ready byte channel.
module mem_hex_dump
  import mem_hex_dump_pkg::*;
#(
  parameter int WPL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] adr_bgn,
  input  logic [15:0] wcnt,
  output logic [15:0] mem_adr,
  output logic        mem_rd,
  input  logic [15:0] mem_dat,
  output logic [7:0]  tx_dat,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy,
  output logic        done
);
  localparam int LW = $clog2(WPL) + 1;

  state_t        r_st, w_nxt;
  logic [15:0]   r_adr, r_rem, r_word;
  logic [LW-1:0] r_lpos;
  logic [1:0]    r_dig;
  logic [2:0]    r_hpos;
  logic [15:0]   w_nsrc;
  logic [1:0]    w_nidx;
  logic [3:0]    w_nib;
  logic [7:0]    w_hex;
  logic          w_xfer, w_last, w_eol;

  assign w_xfer = tx_vld & tx_rdy;
  assign w_last = (r_rem == 16'd1);
  assign w_eol  = w_last || (r_lpos == LW'(WPL - 1));

  // Header positions 1..4 carry the address digits; data words use r_dig.
  assign w_nsrc = (r_st == ADR) ? r_adr : r_word;
  assign w_nidx = (r_st == ADR) ? (r_hpos[1:0] - 2'd1) : r_dig;
  assign w_nib  = w_nsrc[{~w_nidx, 2'b11} -: 4];

  mem_hex_dump_nib u_nib (.i_nib(w_nib), .o_chr(w_hex));

  assign mem_adr = r_adr;
  assign mem_rd  = (r_st == FETCH);
  assign done    = (r_st == FIN);
  assign busy    = (r_st != IDLE) && (r_st != FIN);

  always_comb begin
    w_nxt  = r_st;
    tx_vld = 1'b0;
    tx_dat = 8'h00;
    case (r_st)
      IDLE:  if (start) w_nxt = (wcnt != 16'd0) ? ADR : FIN;
      ADR: begin
        tx_vld = 1'b1;
        tx_dat = (r_hpos == 3'd0) ? chr_atm : (r_hpos == 3'd5) ? chr_lf : w_hex;
        if (tx_rdy && r_hpos == 3'd5) w_nxt = FETCH;
      end
      FETCH: w_nxt = WAIT;
      WAIT:  w_nxt = HEX;
      HEX: begin
        tx_vld = 1'b1;
        tx_dat = w_hex;
        if (tx_rdy && r_dig == 2'd3) w_nxt = SEP;
      end
      SEP: begin
        tx_vld = 1'b1;
        tx_dat = w_eol ? chr_lf : chr_spc;
        if (tx_rdy) w_nxt = w_last ? FIN : FETCH;
      end
      FIN:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= IDLE;
      r_adr  <= 16'h0000;
      r_rem  <= 16'h0000;
      r_word <= 16'h0000;
      r_lpos <= '0;
      r_dig  <= 2'd0;
      r_hpos <= 3'd0;
    end else begin
      r_st <= w_nxt;
      case (r_st)
        IDLE: if (start && wcnt != 16'd0) begin
          r_adr  <= adr_bgn;
          r_rem  <= wcnt;
          r_lpos <= '0;
          r_dig  <= 2'd0;
          r_hpos <= 3'd0;
        end
        ADR:  if (w_xfer) r_hpos <= r_hpos + 3'd1;
        WAIT: r_word <= mem_dat;
        HEX:  if (w_xfer) r_dig <= r_dig + 2'd1;
        SEP: if (w_xfer) begin
          r_rem  <= r_rem - 16'd1;
          r_lpos <= w_eol ? '0 : r_lpos + 1'b1;
          // Address stays on the final word; it wraps naturally past 0xffff.
          if (!w_last) r_adr <= r_adr + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_hex_dump.sv
// Scoreboard bench: expected text/addresses queued at stimulus, checked by a monitor.
module tb_mem_hex_dump;
  localparam int WPL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] adr_bgn = 16'h0, wcnt = 16'h0;
  logic [15:0] mem_adr, mem_dat = 16'h0;
  logic        mem_rd, tx_vld, busy, done;
  logic [7:0]  tx_dat;
  logic        tx_rdy = 1'b1;

  mem_hex_dump #(.WPL(WPL)) dut (
    .clk(clk), .rst(rst), .start(start), .adr_bgn(adr_bgn), .wcnt(wcnt),
    .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_dat(mem_dat),
    .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [7:0]  exp_q[$];
  logic [15:0] expa_q[$];
  int npass = 0, ntot = 0;
  int done_cnt = 0, chars_seen = 0;
  int mode = 0;
  logic       held_v = 1'b0;
  logic [7:0] held_d = 8'h0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  always @(posedge clk) if (mem_rd) mem_dat <= mem[mem_adr];

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = 1'($urandom % 2);
      default: tx_rdy = 1'b0;
    endcase
  end

  always @(negedge clk) if (!rst) begin
    if (done) done_cnt++;
    if (mem_rd) begin
      if (expa_q.size() == 0) chk("mem_adr_extra", mem_adr, -1);
      else chk("mem_adr", mem_adr, expa_q.pop_front());
    end
    if (tx_vld) begin
      if (held_v) chk("tx_dat_stable", tx_dat, held_d);
      if (tx_rdy) begin
        held_v = 1'b0;
        chars_seen++;
        if (exp_q.size() == 0) chk("tx_extra", tx_dat, -1);
        else chk("tx_char", tx_dat, exp_q.pop_front());
      end else begin
        held_v = 1'b1;
        held_d = tx_dat;
      end
    end else held_v = 1'b0;
  end

  function automatic void push_hex(input logic [15:0] v);
    for (int k = 3; k >= 0; k--) begin
      int d;
      d = (v >> (4 * k)) & 15;
      exp_q.push_back(d < 10 ? 8'(48 + d) : 8'(87 + d));
    end
  endfunction

  // Reference text: header, then words with LF after every WPL-th and the last.
  function automatic void build(input logic [15:0] a, input int n);
    if (n == 0) return;
    exp_q.push_back(8'h40);
    push_hex(a);
    exp_q.push_back(8'h0a);
    for (int i = 0; i < n; i++) begin
      logic [15:0] wa;
      wa = 16'(a + i);
      expa_q.push_back(wa);
      push_hex(mem[wa]);
      exp_q.push_back(((i + 1) % WPL == 0 || i == n - 1) ? 8'h0a : 8'h20);
    end
  endfunction

  task automatic start_dump(input logic [15:0] a, input int n);
    build(a, n);
    done_cnt = 0;
    chars_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; adr_bgn = a; wcnt = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; adr_bgn = 16'($urandom); wcnt = 16'($urandom);
    if (n != 0) begin
      chk("busy_after_start", busy, 1);
      chk("vld_after_start", tx_vld, 1);
    end else begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
    end
  endtask

  task automatic finish_dump;
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    chk("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("chars_left", exp_q.size(), 0);
    chk("adrs_left", expa_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    #2;
    chk("rst_vld", tx_vld, 0); chk("rst_dat", tx_dat, 0); chk("rst_rd", mem_rd, 0);
    chk("rst_adr", mem_adr, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    #10 rst = 1'b0;

    mem[16'h40] = 16'h1234; mem[16'h41] = 16'habcd; mem[16'h42] = 16'h0000;
    start_dump(16'h0040, 3); finish_dump();

    start_dump(16'h1000, 9); finish_dump();

    start_dump(16'hffff, 2); finish_dump();

    start_dump(16'h0000, 0); finish_dump();

    // Hold tx_rdy low for 5 cycles on the second header digit.
    chars_seen = 0;
    fork
      begin start_dump(16'h0040, 3); finish_dump(); end
      begin
        for (int k = 0; k < 200 && chars_seen < 2; k++) @(negedge clk);
        mode = 2;
        repeat (5) @(posedge clk);
        mode = 0;
      end
    join

    // A start during a running dump must be ignored.
    start_dump(16'h2222, 5);
    repeat (8) @(posedge clk);
    #1 start = 1'b1; adr_bgn = 16'h3333; wcnt = 16'd3;
    @(posedge clk); #1 start = 1'b0;
    finish_dump();

    mode = 1;
    for (int t = 0; t < 6; t++) begin
      start_dump(16'($urandom), int'($urandom_range(1, 20)));
      finish_dump();
    end

    // Reset mid-dump, then a fresh dump must start with '@'.
    start_dump(16'h5000, 20);
    repeat (30) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_vld", tx_vld, 0); chk("mid_rst_dat", tx_dat, 0); chk("mid_rst_rd", mem_rd, 0);
    chk("mid_rst_adr", mem_adr, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    exp_q.delete(); expa_q.delete(); held_v = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    start_dump(16'h0abc, 4); finish_dump();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
